// File: rtl/seq_step_gen.sv
// Step-sequence generator: walks DEPTH steps, driving out1/out2 from a step table.
// Define SEQ_STEP_GEN_LOAD_EN to make the table runtime-loadable registers.
module seq_step_gen #(
    parameter  int WIDTH     = 3,
    parameter  int DEPTH     = 5,
    parameter  int JUMP_STEP = 2,
    parameter  int WRAP      = 1,
    localparam int SW        = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             restart,
    input  logic             pause,
    input  logic             jump,
    input  logic             load_en,
    input  logic [SW-1:0]    load_addr,
    input  logic [WIDTH-1:0] load_d1,
    input  logic [WIDTH-1:0] load_d2,
    output logic [SW-1:0]    step,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic             odd,
    output logic             even,
    output logic             terminal
);

    localparam logic [SW-1:0] LAST = SW'(DEPTH - 1);
    localparam logic [SW-1:0] JMP  = SW'(JUMP_STEP);

    logic [SW-1:0] step_nxt;

    // jump outranks restart, but only counts in the terminal step
    always_comb begin
        step_nxt = step;
        if (jump && step == LAST)
            step_nxt = JMP;
        else if (restart)
            step_nxt = '0;
        else if (pause)
            step_nxt = step;
        else if (step == LAST)
            step_nxt = (WRAP != 0) ? '0 : LAST;
        else
            step_nxt = step + SW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            step <= '0;
        else
            step <= step_nxt;
    end

    assign terminal = (step == LAST);
    assign odd      = ~step[0];
    assign even     = step[0];

`ifdef SEQ_STEP_GEN_LOAD_EN
    logic [DEPTH-1:0][WIDTH-1:0] tbl1, tbl2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl1[i] <= WIDTH'(2 * i + 1);
                tbl2[i] <= WIDTH'(2 * i);
            end
        end else if (load_en && 32'(load_addr) < DEPTH) begin
            tbl1[load_addr] <= load_d1;
            tbl2[load_addr] <= load_d2;
        end
    end

    assign out1 = tbl1[step];
    assign out2 = tbl2[step];
`else
    logic unused_load;
    assign unused_load = ^{load_en, load_addr, load_d1, load_d2};

    // constant table: entry i is {2i+1, 2i} truncated to WIDTH
    assign out1 = WIDTH'((32'(step) << 1) + 32'd1);
    assign out2 = WIDTH'(32'(step) << 1);
`endif

endmodule

// File: tb/tb_seq_step_gen.sv
// Randomized bench for seq_step_gen: WRAP=1 and WRAP=0 instances share inputs and
// are checked every cycle against an integer-level model, plus literal spot checks.
module tb_seq_step_gen;
    localparam int WIDTH = 3;
    localparam int DEPTH = 5;
    localparam int JSTEP = 2;
    localparam int SW    = 3;

    logic clk = 0;
    logic rst_n = 0;
    logic restart = 0, pause = 0, jump = 0, load_en = 0;
    logic [SW-1:0]    load_addr = '0;
    logic [WIDTH-1:0] load_d1 = '0, load_d2 = '0;

    logic [SW-1:0]    step_w, step_s;
    logic [WIDTH-1:0] o1_w, o2_w, o1_s, o2_s;
    logic             odd_w, even_w, term_w, odd_s, even_s, term_s;

    int checks = 0, errors = 0;
    bit chk_en = 0;

    int m_step [2];
    int m_d1   [2][DEPTH];
    int m_d2   [2][DEPTH];

    always #5 clk = ~clk;

    seq_step_gen #(.WIDTH(WIDTH), .DEPTH(DEPTH), .JUMP_STEP(JSTEP), .WRAP(1)) u_wrap (
        .clk(clk), .rst_n(rst_n), .restart(restart), .pause(pause), .jump(jump),
        .load_en(load_en), .load_addr(load_addr), .load_d1(load_d1), .load_d2(load_d2),
        .step(step_w), .out1(o1_w), .out2(o2_w), .odd(odd_w), .even(even_w),
        .terminal(term_w));

    seq_step_gen #(.WIDTH(WIDTH), .DEPTH(DEPTH), .JUMP_STEP(JSTEP), .WRAP(0)) u_stop (
        .clk(clk), .rst_n(rst_n), .restart(restart), .pause(pause), .jump(jump),
        .load_en(load_en), .load_addr(load_addr), .load_d1(load_d1), .load_d2(load_d2),
        .step(step_s), .out1(o1_s), .out2(o2_s), .odd(odd_s), .even(even_s),
        .terminal(term_s));

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_step[k] = 0;
            for (int i = 0; i < DEPTH; i++) begin
                m_d1[k][i] = (2 * i + 1) % (1 << WIDTH);
                m_d2[k][i] = (2 * i) % (1 << WIDTH);
            end
        end
    endfunction

    // k=0 is the wrapping instance, k=1 the stopping one
    function automatic void model_edge();
        for (int k = 0; k < 2; k++) begin
            int s;
            s = m_step[k];
`ifdef SEQ_STEP_GEN_LOAD_EN
            if (load_en && int'(load_addr) < DEPTH) begin
                m_d1[k][load_addr] = int'(load_d1);
                m_d2[k][load_addr] = int'(load_d2);
            end
`endif
            if (jump && s == DEPTH - 1)  m_step[k] = JSTEP;
            else if (restart)            m_step[k] = 0;
            else if (pause)              m_step[k] = s;
            else if (s == DEPTH - 1)     m_step[k] = (k == 0) ? 0 : DEPTH - 1;
            else                         m_step[k] = s + 1;
        end
    endfunction

    task automatic cmp_dut(input int k, input int st, input int a1, input int a2,
                           input bit od, input bit ev, input bit tm);
        int s;
        bit eod, etm;
        s   = m_step[k];
        eod = (s % 2) == 0;
        etm = (s == DEPTH - 1);
        checks++;
        if (st != s || a1 != m_d1[k][s] || a2 != m_d2[k][s] || od != eod || ev != !eod
            || tm != etm) begin
            errors++;
            $display("FAIL model_cmp dut%0d t=%0t got step=%0d o1=%0d o2=%0d odd=%0b even=%0b term=%0b exp step=%0d o1=%0d o2=%0d odd=%0b even=%0b term=%0b",
                     k, $time, st, a1, a2, od, ev, tm, s, m_d1[k][s], m_d2[k][s], eod, !eod, etm);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            cmp_dut(0, int'(step_w), int'(o1_w), int'(o2_w), odd_w, even_w, term_w);
            cmp_dut(1, int'(step_s), int'(o1_s), int'(o2_s), odd_s, even_s, term_s);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", name, act, exp);
        end
    endtask

    task automatic cycle(input bit rs, input bit ps, input bit jp, input bit le = 0,
                         input int la = 0, input int d1 = 0, input int d2 = 0);
        restart = rs; pause = ps; jump = jp; load_en = le;
        load_addr = SW'(la); load_d1 = WIDTH'(d1); load_d2 = WIDTH'(d2);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    int exp1 [5] = '{3, 5, 7, 1, 1};
    int exp2 [5] = '{2, 4, 6, 0, 0};
    int expt [5] = '{0, 0, 0, 1, 0};
    int exps [5] = '{1, 2, 3, 4, 4};

    initial begin
        model_reset();
        #12 rst_n = 1;
        chk("rst_step", int'(step_w), 0);
        chk("rst_out1", int'(o1_w), 1);
        chk("rst_out2", int'(o2_w), 0);
        chk("rst_odd", int'(odd_w), 1);
        chk("rst_even", int'(even_w), 0);
        chk("rst_term", int'(term_w), 0);
        chk_en = 1;

        // free run: wrap instance cycles back to 0, stop instance parks at 4
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 0);
            chk("run_out1", int'(o1_w), exp1[i]);
            chk("run_out2", int'(o2_w), exp2[i]);
            chk("run_term", int'(term_w), expt[i]);
            chk("stop_step", int'(step_s), exps[i]);
        end
        chk("stop_term", int'(term_s), 1);

        // pause at step 2
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 0);
            chk("pause_step", int'(step_w), 2);
            chk("pause_out1", int'(o1_w), 5);
            chk("pause_out2", int'(o2_w), 4);
        end
        cycle(0, 0, 0);
        chk("unpause_step", int'(step_w), 3);

        // jump ignored off the terminal step; jump beats restart at step 4
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        cycle(0, 0, 1);
        chk("jump_ignored", int'(step_w), 2);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        chk("at_term", int'(term_w), 1);
        cycle(1, 0, 1);
        chk("jump_step", int'(step_w), 2);
        chk("jump_term", int'(term_w), 0);
        cycle(1, 0, 0);
        chk("stop_restart", int'(step_s), 0);

`ifdef SEQ_STEP_GEN_LOAD_EN
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        cycle(0, 0, 0, 1, 3, 2, 5);
        chk("load_out1", int'(o1_w), 2);
        chk("load_out2", int'(o2_w), 5);
        cycle(0, 1, 0, 1, 6, 7, 7);
        chk("load_oob", int'(o1_w), 2);
        cycle(1, 0, 0);
`endif

        // async reset between edges at step 3
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        chk("pre_rst_step", int'(step_w), 3);
        #2 rst_n = 0;
        #1;
        chk("async_step", int'(step_w), 0);
        chk("async_out1", int'(o1_w), 1);
        chk("async_out2", int'(o2_w), 0);
        model_reset();
        #3 rst_n = 1;
        cycle(0, 0, 0);
        chk("post_rst_step", int'(step_w), 1);

        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(7) == 0, $urandom_range(3) == 0, $urandom_range(2) == 0,
                  $urandom_range(3) == 0, int'($urandom_range(7)),
                  int'($urandom_range(7)), int'($urandom_range(7)));
        end

        @(negedge clk);
        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
